// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit for the multicycle RISC-V datapath.
// Owns PC and IR, fetches over a req/ack handshake, applies branch redirects.
module instr_fetch_unit #(
    parameter int unsigned           XLEN     = 64,
    parameter logic [XLEN-1:0]       RESET_PC = '0,
    parameter int unsigned           TIMEOUT  = 15
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            fetch_start,
    input  logic            pc_write,
    input  logic            pc_write_cond,
    input  logic            pc_src,
    input  logic [1:0]      branch_op,
    input  logic            alu_zero,
    input  logic            alu_less,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ack,
    output logic [31:0]     instruction,
    output logic            instr_valid,
    output logic [XLEN-1:0] pc,
    output logic            busy,
    output logic            fetch_fault,
    output logic [1:0]      fault_cause
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        FAULT
    } state_t;

    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [7:0]  CNT_LAST  = 8'(TIMEOUT - 1);

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc_nxt, addr_nxt;
    logic [31:0]     instr_nxt;
    logic            req_nxt, busy_nxt, valid_nxt, fault_nxt;
    logic [1:0]      cause_nxt;
    logic            pending, pending_nxt;
    logic [7:0]      cnt, cnt_nxt;

    logic take, redirect, start;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instruction <= NOP;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            busy        <= 1'b0;
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
            fault_cause <= 2'b00;
            pending     <= 1'b0;
            cnt         <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            instruction <= instr_nxt;
            imem_req    <= req_nxt;
            imem_addr   <= addr_nxt;
            busy        <= busy_nxt;
            instr_valid <= valid_nxt;
            fetch_fault <= fault_nxt;
            fault_cause <= cause_nxt;
            pending     <= pending_nxt;
            cnt         <= cnt_nxt;
        end
    end

    always_comb begin
        take = 1'b0;
        unique case (branch_op)
            2'b00: take = alu_zero;
            2'b01: take = ~alu_zero;
            2'b10: take = ~alu_less;
            2'b11: take = alu_less;
            default: take = 1'b0;
        endcase
    end

    assign redirect = pc_src & (pc_write | (pc_write_cond & take));
    assign start    = fetch_start | pending;

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        instr_nxt   = instruction;
        req_nxt     = imem_req;
        addr_nxt    = imem_addr;
        busy_nxt    = busy;
        valid_nxt   = 1'b0;
        fault_nxt   = fetch_fault;
        cause_nxt   = fault_cause;
        pending_nxt = pending;
        cnt_nxt     = cnt;

        unique case (state)
            IDLE: begin
                // Redirect wins; a coincident start is replayed next cycle on the new PC.
                if (redirect) begin
                    pc_nxt      = branch_target;
                    pending_nxt = start;
                end else if (start) begin
                    pending_nxt = 1'b0;
                    if (pc[1:0] != 2'b00) begin
                        state_nxt = FAULT;
                        fault_nxt = 1'b1;
                        cause_nxt = 2'b01;
                    end else begin
                        state_nxt = WAIT;
                        req_nxt   = 1'b1;
                        addr_nxt  = pc;
                        busy_nxt  = 1'b1;
                        cnt_nxt   = '0;
                    end
                end
            end
            WAIT: begin
                if (imem_ack) begin
                    state_nxt = IDLE;
                    instr_nxt = imem_rdata;
                    pc_nxt    = pc + XLEN'(4);
                    req_nxt   = 1'b0;
                    busy_nxt  = 1'b0;
                    valid_nxt = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = FAULT;
                    fault_nxt = 1'b1;
                    cause_nxt = 2'b10;
                    req_nxt   = 1'b0;
                    busy_nxt  = 1'b0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            FAULT: begin
                req_nxt  = 1'b0;
                busy_nxt = 1'b0;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed and randomized bench for instr_fetch_unit.
// Expected PC/IR come from a transaction-level model kept in the bench.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic        fetch_start;
    logic        pc_write;
    logic        pc_write_cond;
    logic        pc_src;
    logic [1:0]  branch_op;
    logic        alu_zero;
    logic        alu_less;
    logic [63:0] branch_target;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [63:0] pc;
    logic        busy;
    logic        fetch_fault;
    logic [1:0]  fault_cause;

    int passed = 0;
    int total  = 0;

    logic [63:0] m_pc;
    logic [31:0] m_ir;

    localparam logic [31:0] NOP = 32'h0000_0013;

    instr_fetch_unit dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .fetch_start   (fetch_start),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_src        (pc_src),
        .branch_op     (branch_op),
        .alu_zero      (alu_zero),
        .alu_less      (alu_less),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_ack      (imem_ack),
        .instruction   (instruction),
        .instr_valid   (instr_valid),
        .pc            (pc),
        .busy          (busy),
        .fetch_fault   (fetch_fault),
        .fault_cause   (fault_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        fetch_start   = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 1'b0;
        branch_op     = 2'b00;
        alu_zero      = 1'b0;
        alu_less      = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        m_pc = 64'd0;
        m_ir = NOP;
        check("rst_pc", pc, m_pc);
        check("rst_ir", {32'd0, instruction}, {32'd0, m_ir});
        check("rst_req", {63'd0, imem_req}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_fault", {63'd0, fetch_fault}, 64'd0);
        check("rst_cause", {62'd0, fault_cause}, 64'd0);
        check("rst_valid", {63'd0, instr_valid}, 64'd0);
    endtask

    // Fetch with ack arriving after lat idle WAIT cycles; noise pokes ignored inputs.
    task automatic fetch(input int lat, input logic [31:0] rdata, input bit noise);
        int hi;
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        check("f_req", {63'd0, imem_req}, 64'd1);
        check("f_addr", imem_addr, m_pc);
        check("f_busy", {63'd0, busy}, 64'd1);
        hi = (imem_req === 1'b1) ? 1 : 0;
        for (int i = 0; i < lat; i++) begin
            if (noise) begin
                pc_write      = 1'b1;
                pc_src        = 1'b1;
                fetch_start   = 1'($urandom_range(0, 1));
                branch_target = {$urandom, $urandom};
            end
            step();
            clear_ctl();
            if (imem_req === 1'b1) hi++;
            check("w_addr", imem_addr, m_pc);
            check("w_pc", pc, m_pc);
        end
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        step();
        imem_ack = 1'b0;
        m_pc = m_pc + 64'd4;
        m_ir = rdata;
        check("req_cycles", 64'(hi), 64'(lat + 1));
        check("a_ir", {32'd0, instruction}, {32'd0, m_ir});
        check("a_pc", pc, m_pc);
        check("a_valid", {63'd0, instr_valid}, 64'd1);
        check("a_busy", {63'd0, busy}, 64'd0);
        check("a_req", {63'd0, imem_req}, 64'd0);
        step();
        check("v_pulse", {63'd0, instr_valid}, 64'd0);
    endtask

    task automatic branch(input bit uncond, input logic [1:0] op, input bit z,
                          input bit l, input logic [63:0] tgt);
        bit tk;
        pc_write      = uncond;
        pc_write_cond = !uncond;
        pc_src        = 1'b1;
        branch_op     = op;
        alu_zero      = z;
        alu_less      = l;
        branch_target = tgt;
        step();
        clear_ctl();
        case (op)
            2'b00: tk = z;
            2'b01: tk = !z;
            2'b10: tk = !l;
            default: tk = l;
        endcase
        if (uncond || tk) m_pc = tgt;
        check("br_pc", pc, m_pc);
        check("br_req", {63'd0, imem_req}, 64'd0);
    endtask

    initial begin
        reset_n       = 1'b0;
        imem_ack      = 1'b0;
        imem_rdata    = 32'd0;
        branch_target = 64'd0;
        clear_ctl();
        step();
        do_reset();

        fetch(3, 32'h0050_0093, 1'b0);
        fetch(2, 32'h1234_5678, 1'b0);

        // Branch truth table from pc=8.
        for (int op = 0; op < 4; op++) begin
            for (int zl = 0; zl < 4; zl++) begin
                branch(1'b0, 2'(op), zl[0], zl[1], 64'h40);
                branch(1'b1, 2'b00, 1'b0, 1'b0, 64'h8);
            end
        end

        // pc_write without pc_src is a no-op.
        pc_write = 1'b1;
        branch_target = 64'h200;
        step();
        clear_ctl();
        check("nosrc_pc", pc, m_pc);

        // Stray ack in IDLE leaves IR alone.
        imem_ack   = 1'b1;
        imem_rdata = 32'hdead_beef;
        step();
        imem_ack = 1'b0;
        check("stray_ir", {32'd0, instruction}, {32'd0, m_ir});
        check("stray_valid", {63'd0, instr_valid}, 64'd0);

        // Redirect and fetch_start together: launch delayed one cycle.
        fetch_start   = 1'b1;
        pc_write      = 1'b1;
        pc_src        = 1'b1;
        branch_target = 64'h100;
        step();
        clear_ctl();
        m_pc = 64'h100;
        check("same_pc", pc, m_pc);
        check("same_req0", {63'd0, imem_req}, 64'd0);
        step();
        check("same_req1", {63'd0, imem_req}, 64'd1);
        check("same_addr", imem_addr, 64'h100);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0033;
        step();
        imem_ack = 1'b0;
        m_pc = 64'h104;
        m_ir = 32'h0000_0033;
        check("same_ack_pc", pc, m_pc);
        check("same_ack_ir", {32'd0, instruction}, {32'd0, m_ir});
        step();

        // Randomized mix; ack latency up to the last non-fault cycle.
        fetch(14, 32'hcafe_f00d, 1'b0);
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 1) == 0)
                fetch(int'($urandom_range(0, 14)), $urandom, 1'($urandom_range(0, 1)));
            else
                branch(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       {$urandom, $urandom} & ~64'd3);
        end

        // Timeout: 15 WAIT cycles with no ack.
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step();
            check("to_req", {63'd0, imem_req}, 64'd1);
        end
        step();
        check("to_fault", {63'd0, fetch_fault}, 64'd1);
        check("to_cause", {62'd0, fault_cause}, 64'd2);
        check("to_req0", {63'd0, imem_req}, 64'd0);
        check("to_busy", {63'd0, busy}, 64'd0);
        check("to_pc", pc, m_pc);
        fetch_start   = 1'b1;
        pc_write      = 1'b1;
        pc_src        = 1'b1;
        branch_target = 64'h0;
        imem_ack      = 1'b1;
        imem_rdata    = 32'h1111_1111;
        for (int i = 0; i < 3; i++) begin
            step();
            check("flt_req", {63'd0, imem_req}, 64'd0);
            check("flt_pc", pc, m_pc);
            check("flt_ir", {32'd0, instruction}, {32'd0, m_ir});
            check("flt_cause", {62'd0, fault_cause}, 64'd2);
        end
        clear_ctl();
        imem_ack = 1'b0;
        do_reset();

        // Misaligned target accepted, fault raised at next fetch_start.
        branch(1'b1, 2'b00, 1'b0, 1'b0, 64'h102);
        check("mis_nofault", {63'd0, fetch_fault}, 64'd0);
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        check("mis_fault", {63'd0, fetch_fault}, 64'd1);
        check("mis_cause", {62'd0, fault_cause}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            check("mis_req", {63'd0, imem_req}, 64'd0);
            step();
        end
        do_reset();

        // Reset mid-fetch; later ack ignored.
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        step();
        check("mid_req", {63'd0, imem_req}, 64'd1);
        do_reset();
        imem_ack   = 1'b1;
        imem_rdata = 32'h0bad_0bad;
        step();
        imem_ack = 1'b0;
        check("mid_pc", pc, 64'd0);
        check("mid_ir", {32'd0, instruction}, {32'd0, NOP});
        check("mid_valid", {63'd0, instr_valid}, 64'd0);
        check("mid_req0", {63'd0, imem_req}, 64'd0);

        fetch(1, 32'h0000_0073, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
